// File: rtl/bomberman_pkg.sv
// Shared keypad constants, column-scan state type and player B action mapping.
package bomberman_pkg;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  // Player B actions consumed by chara_control
  localparam logic [3:0] KEY_UP    = KEY_2;
  localparam logic [3:0] KEY_DOWN  = KEY_8;
  localparam logic [3:0] KEY_LEFT  = KEY_4;
  localparam logic [3:0] KEY_RIGHT = KEY_6;
  localparam logic [3:0] KEY_BOMB  = KEY_5;

  typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_state_t;

  // Sweep candidate: a key code, or none when no single key was seen
  typedef struct packed {
    logic       none;
    logic [3:0] code;
  } key_cand_t;

  localparam key_cand_t CAND_NONE = '{none: 1'b1, code: 4'h0};

  // Label printed on the keypad at (column, row), row0 at top
  function automatic logic [3:0] keyAt(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] k;
    k = KEY_0;
    case ({c, r})
      4'd0:  k = KEY_1;
      4'd1:  k = KEY_4;
      4'd2:  k = KEY_7;
      4'd3:  k = KEY_0;
      4'd4:  k = KEY_2;
      4'd5:  k = KEY_5;
      4'd6:  k = KEY_8;
      4'd7:  k = KEY_F;
      4'd8:  k = KEY_3;
      4'd9:  k = KEY_6;
      4'd10: k = KEY_9;
      4'd11: k = KEY_E;
      4'd12: k = KEY_A;
      4'd13: k = KEY_B;
      4'd14: k = KEY_C;
      4'd15: k = KEY_D;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
  parameter int unsigned     WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with per-sweep ghost rejection and debounce;
// emits a held key level and a one-cycle press pulse.
module keypad_scanner
  import bomberman_pkg::*;
#(
  parameter int unsigned SCAN_TICKS     = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pulse
);

  localparam int unsigned TICK_W = $clog2(SCAN_TICKS);
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(SCAN_TICKS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_SCANS);

  logic [3:0]        syncRow;
  col_state_t        state;
  col_state_t        stateNext;
  logic [TICK_W-1:0] tickCnt;
  logic [2:0][3:0]   samples;
  logic              lastTick;
  logic              evalNow;

  logic [15:0]       sweepLow;
  logic [4:0]        lowCnt;
  logic [3:0]        hitIdx;
  key_cand_t         cand;
  key_cand_t         accepted;

  key_cand_t         lastCand;
  key_cand_t         lastCandNext;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cntNext;
  logic [3:0]        codeNext;
  logic              validNext;
  logic              pulseNext;

  sync_2ff #(.WIDTH(4), .RESET_VAL(4'hF)) u_rowSync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (syncRow)
  );

  function automatic logic [3:0] colFor(input col_state_t s);
    logic [3:0] c;
    c = 4'b1110;
    case (s)
      COL0: c = 4'b1110;
      COL1: c = 4'b1101;
      COL2: c = 4'b1011;
      COL3: c = 4'b0111;
    endcase
    return c;
  endfunction

  assign lastTick = (tickCnt == LAST_TICK);
  assign evalNow  = lastTick && (state == COL3);

  // Column state register; col is registered alongside it
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COL0;
      col   <= 4'b1110;
    end else begin
      state <= stateNext;
      col   <= colFor(stateNext);
    end
  end

  always_comb begin
    stateNext = state;
    if (lastTick) begin
      case (state)
        COL0: stateNext = COL1;
        COL1: stateNext = COL2;
        COL2: stateNext = COL3;
        COL3: stateNext = COL0;
      endcase
    end
  end

  // Sweep evaluation: bit c*4+r set when row r read low while column c driven
  always_comb begin
    sweepLow = ~{syncRow, samples[2], samples[1], samples[0]};
    lowCnt   = '0;
    hitIdx   = '0;
    for (int i = 0; i < 16; i++) begin
      if (sweepLow[i]) begin
        lowCnt = 5'(lowCnt + 5'd1);
        hitIdx = 4'(i);
      end
    end
    cand = CAND_NONE;
    if (lowCnt == 5'd1) begin
      cand = '{none: 1'b0, code: keyAt(hitIdx[3:2], hitIdx[1:0])};
    end
  end

  assign accepted = key_valid ? key_cand_t'({1'b0, key_code}) : CAND_NONE;

  // Debounce: accept a candidate once it has been seen on enough consecutive sweeps
  always_comb begin
    lastCandNext = lastCand;
    cntNext      = cnt;
    codeNext     = key_code;
    validNext    = key_valid;
    pulseNext    = 1'b0;
    if (evalNow) begin
      if (cand == lastCand) begin
        cntNext = (cnt == CNT_MAX) ? cnt : CNT_W'(cnt + 1'b1);
      end else begin
        cntNext      = CNT_W'(1);
        lastCandNext = cand;
      end
      if ((cntNext == CNT_MAX) && (cand != accepted)) begin
        if (cand.none) begin
          validNext = 1'b0;
        end else begin
          codeNext  = cand.code;
          validNext = 1'b1;
          pulseNext = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tickCnt   <= '0;
      samples   <= '1;
      lastCand  <= CAND_NONE;
      cnt       <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_pulse <= 1'b0;
    end else begin
      tickCnt <= lastTick ? '0 : TICK_W'(tickCnt + 1'b1);
      if (lastTick) begin
        case (state)
          COL0:    samples[0] <= syncRow;
          COL1:    samples[1] <= syncRow;
          COL2:    samples[2] <= syncRow;
          default: ;
        endcase
      end
      lastCand  <= lastCandNext;
      cnt       <= cntNext;
      key_code  <= codeNext;
      key_valid <= validNext;
      key_pulse <= pulseNext;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model plus a sweep-level reference
// that accepts a key once the last DEB sweep results agree.
module tb_keypad_scanner;

  localparam int SCAN  = 8;
  localparam int DEB   = 3;
  localparam int SWEEP = 4 * SCAN;
  localparam int NONE  = 16;

  logic       clk;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_pulse;

  logic [15:0] pressedMask;
  int checks = 0;
  int errors = 0;

  int       phase;
  int       history[$];
  int       sweepCand;
  bit       expValid;
  logic [3:0] expCode;
  bit       expPulse;

  // Label at index c*4+r
  int labelTab[16] = '{1, 4, 7, 0, 2, 5, 8, 15, 3, 6, 9, 14, 10, 11, 12, 13};

  keypad_scanner #(.SCAN_TICKS(SCAN), .DEBOUNCE_SCANS(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_pulse (key_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && pressedMask[c*4+r]) row[r] = 1'b0;
  end

  function automatic int candOf(input logic [15:0] m);
    if ($countones(m) != 1) return NONE;
    for (int i = 0; i < 16; i++) if (m[i]) return labelTab[i];
    return NONE;
  endfunction

  function automatic logic [15:0] maskOf(input int label);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) if (labelTab[i] == label) m[i] = 1'b1;
    return m;
  endfunction

  task automatic modelReset();
    history.delete();
    expValid = 1'b0;
    expCode  = 4'h0;
    expPulse = 1'b0;
    phase    = 0;
  endtask

  task automatic endSweep();
    int n;
    bit same;
    int acc;
    history.push_back(sweepCand);
    expPulse = 1'b0;
    n = history.size();
    acc = expValid ? int'(expCode) : NONE;
    if (n >= DEB) begin
      same = 1'b1;
      for (int k = 1; k < DEB; k++) if (history[n-1-k] != history[n-1]) same = 1'b0;
      if (same && history[n-1] != acc) begin
        if (history[n-1] == NONE) expValid = 1'b0;
        else begin
          expValid = 1'b1;
          expCode  = 4'(history[n-1]);
          expPulse = 1'b1;
        end
      end
    end
  endtask

  task automatic checkCycle();
    logic [3:0] expCol;
    bit ep;
    expCol = ~(4'b0001 << (phase / SCAN));
    ep = (phase == 0) ? expPulse : 1'b0;
    checks++;
    if (col !== expCol) begin
      errors++;
      $display("FAIL col: got %b expected %b (phase %0d, t=%0t)", col, expCol, phase, $time);
    end
    checks++;
    if (key_pulse !== ep) begin
      errors++;
      $display("FAIL key_pulse: got %b expected %b (phase %0d, t=%0t)", key_pulse, ep, phase, $time);
    end
    checks++;
    if (key_valid !== expValid) begin
      errors++;
      $display("FAIL key_valid: got %b expected %b (phase %0d, t=%0t)", key_valid, expValid, phase, $time);
    end
    checks++;
    if (key_code !== expCode) begin
      errors++;
      $display("FAIL key_code: got %h expected %h (phase %0d, t=%0t)", key_code, expCode, phase, $time);
    end
  endtask

  task automatic step();
    checkCycle();
    @(posedge clk);
    #1;
    phase++;
    if (phase == SWEEP) begin
      phase = 0;
      endSweep();
    end
  endtask

  task automatic runSweep(input logic [15:0] m);
    pressedMask = m;
    sweepCand   = candOf(m);
    repeat (SWEEP) step();
  endtask

  task automatic applyReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  task automatic test_reset();
    pressedMask = '0;
    applyReset();
    repeat (4) runSweep('0);
  endtask

  task automatic test_press_release();
    repeat (13) runSweep(maskOf(5));
    repeat (4) runSweep('0);
  endtask

  task automatic test_bounce();
    repeat (2) begin
      runSweep(maskOf(8));
      runSweep('0);
    end
    runSweep('0);
  endtask

  task automatic test_ghosting();
    repeat (4) runSweep(maskOf(1) | maskOf(2));
    repeat (3) runSweep('0);
    repeat (3) runSweep(maskOf(10));
    repeat (4) runSweep(maskOf(10) | maskOf(11));
    repeat (3) runSweep('0);
  endtask

  task automatic test_back_to_back();
    repeat (3) runSweep(maskOf(10));
    repeat (4) runSweep(maskOf(11));
    repeat (3) runSweep('0);
  endtask

  task automatic test_reset_mid();
    repeat (2) runSweep(maskOf(13));
    repeat (19) step();
    applyReset();
    repeat (5) runSweep(maskOf(13));
    repeat (3) runSweep('0);
  endtask

  task automatic test_random();
    logic [15:0] m;
    int kind;
    int a;
    int b;
    for (int n = 0; n < 25; n++) begin
      kind = int'($urandom_range(0, 9));
      a = int'($urandom_range(0, 15));
      b = (a + int'($urandom_range(1, 15))) % 16;
      m = '0;
      if (kind >= 2) m[a] = 1'b1;
      if (kind == 2) m[b] = 1'b1;
      repeat ($urandom_range(1, 4)) runSweep(m);
    end
    repeat (3) runSweep('0);
  endtask

  initial begin
    rst = 1'b1;
    pressedMask = '0;
    sweepCand = NONE;
    modelReset();
    @(posedge clk);
    #1;
    test_reset();
    test_press_release();
    test_bounce();
    test_ghosting();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the 4x4 Pmod keypad that player B uses, debounces the result, and reports one clean key event. It sits directly upstream of `chara_control`: it drives the keypad columns on JA[3:0], reads the rows on JA[7:4], and replaces the combinational row decode that currently feeds `playerB`. Outputs are `key_code`, a held-level qualifier, and a single-cycle press pulse. Movement and bomb placement consume the pulse, so one physical press yields exactly one action.

## Interface
- `SCAN_TICKS`, default 100000: clk cycles each column is driven (1 ms at 100 MHz). Must be ≥ 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full sweeps required to accept a press or a release. Must be ≥ 1.
- `clk` in, 1: system clock, 100 MHz board clock.
- `rst` in, 1: one clock; reset is synchronous and active-high.
- `row` in, 4: keypad rows, active-low, pulled up externally (JA[7:4]).
- `col` out, 4: keypad columns, active-low, exactly one bit low at all times (JA[3:0]).
- `key_code` out, 4: hex label of the accepted key.
- `key_valid` out, 1: high while an accepted key is held.
- `key_pulse` out, 1: high for one cycle when a key is newly accepted.

## Operation
- Row input passes through a 2-flop synchronizer before any use.
- Column FSM has states COL0 → COL1 → COL2 → COL3 → COL0. Each state lasts `SCAN_TICKS` cycles. `col` = 1110, 1101, 1011, 0111 respectively.
- Rows are sampled on the last cycle of each column window; earlier cycles allow settling and synchronizer latency.
- Key map by (col, row), row0 at top:
  - col0: 1, 4, 7, 0
  - col1: 2, 5, 8, F
  - col2: 3, 6, 9, E
  - col3: A, B, C, D
- Sweep result is evaluated at the end of COL3:
  - exactly one low row bit across all four samples → candidate = that key.
  - zero low bits → candidate = NONE.
  - two or more → candidate = NONE (ghosting/ambiguous rejected).
- Debounce: a 4-bit-plus-none `last_candidate` register and a saturating count.
  - Same candidate as the previous sweep → count increments.
  - Different candidate → count resets to 1 and `last_candidate` updates.
  - When count reaches `DEBOUNCE_SCANS` and the candidate differs from the accepted state, accepted state takes the candidate.
- On acceptance of key K: `key_code` ← K, `key_valid` ← 1, `key_pulse` high for one cycle. This also applies to a direct change from key X to key Y.
- On acceptance of NONE: `key_valid` ← 0, `key_code` holds its last value, no pulse.
- A held key never re-pulses (no auto-repeat).

## Timing
- Reset values: `col` = 1110 (state COL0), tick counter 0, `key_code` 0, `key_valid` 0, `key_pulse` 0, debounce count 0, `last_candidate` NONE.
- Sweep period is 4·`SCAN_TICKS` cycles.
- A press stable from the start of sweep n is accepted at the last cycle of sweep n+`DEBOUNCE_SCANS`−1.
- `key_valid`, `key_code` and `key_pulse` all update on the same clk edge after the end-of-COL3 evaluation.
- `key_pulse` is never high on two consecutive cycles.
- `rst` mid-operation: on the next edge all state returns to the reset values. A partial debounce count is discarded and no pulse is emitted.
- Ambiguous (multi-key) sweeps break a debounce run exactly as a different key would.

## Structure
- `bomberman_pkg` holds:
  - `KEY_0`…`KEY_F` 4-bit constants.
  - the `col_state_t` enum (COL0–COL3).
  - the player B action mapping constants (KEY_2 up, KEY_8 down, KEY_4 left, KEY_6 right, KEY_5 bomb) that `chara_control` uses.
- Sub-module `sync_2ff` (4-bit wide) handles the row synchronizer. The scan FSM, sweep evaluator and debounce logic stay in `keypad_scanner`.

## Test plan
Benches use `SCAN_TICKS`=8, `DEBOUNCE_SCANS`=3. The keypad model pulls `row[r]` low whenever `col[c]` is low and key (c,r) is pressed.
- Reset, idle 100 cycles → `col` steps 1110, 1101, 1011, 0111 with 8 cycles each. `key_valid`/`key_pulse`/`key_code` stay 0.
- Hold key 5 (col1,row1) from sweep start → after exactly 3 sweeps (96 cycles + sync) `key_valid`=1, `key_code`=5, one `key_pulse`; no further pulses while held 10 sweeps. Release → `key_valid`=0 after 3 NONE sweeps, `key_code` stays 5.
- Bounce: key 8 present 1 sweep, absent 1, present 1, absent → no pulse, `key_valid` never 1.
- Keys 1 and 2 held together from idle → no acceptance. With A accepted, add B simultaneously → `key_valid` drops after 3 sweeps, no pulse.
- Hold A until accepted, switch directly to B → `key_code`=B, second `key_pulse`, `key_valid` stays 1 throughout.
- Hold D for 2 sweeps, assert `rst` 1 cycle mid-COL2 → `col`=1110 next cycle. Still holding D, acceptance requires 3 full fresh sweeps; exactly one pulse.
